// File: rtl/instr_fetch_pkg.sv
// Shared types and widths for the RISC-I instruction fetch stage.
// The fetch FSM encoding is exported so checkers can decode the debug state port.
package instr_fetch_pkg;

    localparam int FETCH_ST_LEN    = 3;
    localparam int INSTR_LEN       = 32;
    localparam int PC_LEN          = 32;
    localparam int TIMEOUT_CNT_LEN = 8;

    typedef enum logic [FETCH_ST_LEN-1:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetchState_t;

    // BEQ takes on Zero, BNE takes on not-Zero.
    function automatic logic branchTaken(input logic branch,
                                         input logic notEqualBranch,
                                         input logic zero);
        return (branch & zero) | (notEqualBranch & ~zero);
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next_sel.sv
// Next-PC selection for the fetch stage: jump > taken branch > PC+4.
// Purely combinational; evaluated by instr_fetch on the accept cycle.
module pc_next_sel
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pcPlus4,
    input  logic [25:0] instrLow,
    input  logic        jump,
    input  logic        branch,
    input  logic        notEqualBranch,
    input  logic        zero,
    output logic [31:0] nextPc
);

    logic [31:0] jumpTarget;
    logic [31:0] branchOffset;
    logic [31:0] branchTarget;
    logic [31:0] selPc;
    logic        taken;

    always_comb begin
        jumpTarget   = {pcPlus4[31:28], instrLow, 2'b00};
        branchOffset = {{14{instrLow[15]}}, instrLow[15:0], 2'b00};
        branchTarget = pcPlus4 + branchOffset;
        taken        = branchTaken(branch, notEqualBranch, zero);

        if (jump) begin
            selPc = jumpTarget;
        end else if (taken) begin
            selPc = branchTarget;
        end else begin
            selPc = pcPlus4;
        end

        // Instruction addresses are always word-aligned, whatever the target math says.
        nextPc = {selPc[31:2], 2'b00};
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory request per instruction,
// holds the returned word for the core and flags a sticky fault on memory timeout.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_IMemReq,
    output logic [31:0] o_IMemAddr,
    input  logic        i_IMemValid,
    input  logic [31:0] i_IMemData,
    output logic [31:0] o_Instr,
    output logic [31:0] o_PC,
    output logic [31:0] o_PCPlus4,
    output logic        o_InstrValid,
    input  logic        i_InstrAccept,
    input  logic        i_Jump,
    input  logic        i_Branch,
    input  logic        i_NotEqualBranch,
    input  logic        i_Zero,
    output logic        o_Fault,
    output logic [2:0]  o_FetchState
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [TIMEOUT_CNT_LEN-1:0] TIMEOUT_LAST = TIMEOUT_CNT_LEN'(TIMEOUT_CYC - 1);

    fetchState_t                state;
    fetchState_t                nextState;
    logic [PC_LEN-1:0]          pc;
    logic [PC_LEN-1:0]          pcPlus4;
    logic [PC_LEN-1:0]          nextPc;
    logic [INSTR_LEN-1:0]       instrReg;
    logic [TIMEOUT_CNT_LEN-1:0] timeoutCnt;
    logic                       accepted;
    logic                       respTaken;

    // Handshakes: memory side is a one-cycle o_IMemReq pulse answered later by a
    // one-cycle i_IMemValid, used only in S_WAIT. Core side is valid/ready: the
    // instruction transfers on a cycle where o_InstrValid & i_InstrAccept are both high;
    // o_Instr/o_PC never change while o_InstrValid is high and not yet accepted.
    assign accepted  = (state == S_HOLD) && i_InstrAccept;
    assign respTaken = (state == S_WAIT) && i_IMemValid;
    assign pcPlus4   = pc + 32'd4;

    pc_next_sel u_pcNextSel (
        .pcPlus4        (pcPlus4),
        .instrLow       (instrReg[25:0]),
        .jump           (i_Jump),
        .branch         (i_Branch),
        .notEqualBranch (i_NotEqualBranch),
        .zero           (i_Zero),
        .nextPc         (nextPc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            S_IDLE:  nextState = S_REQ;
            S_REQ:   nextState = S_WAIT;
            S_WAIT: begin
                // A response on the limit cycle still counts: valid beats timeout.
                if (i_IMemValid) begin
                    nextState = S_HOLD;
                end else if (timeoutCnt == TIMEOUT_LAST) begin
                    nextState = S_FAULT;
                end
            end
            S_HOLD: begin
                if (i_InstrAccept) begin
                    nextState = S_REQ;
                end
            end
            S_FAULT: nextState = S_FAULT;
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        o_IMemReq    = (state == S_REQ);
        o_InstrValid = (state == S_HOLD);
        o_Fault      = (state == S_FAULT);
        o_FetchState = state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc         <= RESET_PC_ALIGNED;
            instrReg   <= '0;
            timeoutCnt <= '0;
        end else begin
            if (state == S_REQ) begin
                timeoutCnt <= '0;
            end else if ((state == S_WAIT) && !i_IMemValid && (timeoutCnt != TIMEOUT_LAST)) begin
                timeoutCnt <= timeoutCnt + 1'b1;
            end

            if (respTaken) begin
                instrReg <= i_IMemData;
            end

            if (accepted) begin
                pc <= nextPc;
            end
        end
    end

    assign o_IMemAddr = pc;
    assign o_PC       = pc;
    assign o_PCPlus4  = pcPlus4;
    assign o_Instr    = instrReg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory model answers requests, a core driver
// accepts instructions, and a monitor checks requests/instructions against queues.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          TIMEOUT_CYC = 16;

    localparam logic [31:0] W_RTYPE  = 32'h0000_0020;
    localparam logic [31:0] W_BEQ_M2 = 32'h1000_FFFE;
    localparam logic [31:0] W_BNE_3  = 32'h1400_0003;
    localparam logic [31:0] W_J_2    = 32'h0800_0002;
    localparam logic [31:0] W_J_MAX  = 32'h0BFF_FFFF;
    localparam logic [31:0] W_J_40   = 32'h0800_0040;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_IMemReq;
    logic [31:0] o_IMemAddr;
    logic        i_IMemValid = 1'b0;
    logic [31:0] i_IMemData = 32'h0;
    logic [31:0] o_Instr;
    logic [31:0] o_PC;
    logic [31:0] o_PCPlus4;
    logic        o_InstrValid;
    logic        i_InstrAccept = 1'b0;
    logic        i_Jump = 1'b0;
    logic        i_Branch = 1'b0;
    logic        i_NotEqualBranch = 1'b0;
    logic        i_Zero = 1'b0;
    logic        o_Fault;
    logic [2:0]  o_FetchState;

    instr_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_IMemReq        (o_IMemReq),
        .o_IMemAddr       (o_IMemAddr),
        .i_IMemValid      (i_IMemValid),
        .i_IMemData       (i_IMemData),
        .o_Instr          (o_Instr),
        .o_PC             (o_PC),
        .o_PCPlus4        (o_PCPlus4),
        .o_InstrValid     (o_InstrValid),
        .i_InstrAccept    (i_InstrAccept),
        .i_Jump           (i_Jump),
        .i_Branch         (i_Branch),
        .i_NotEqualBranch (i_NotEqualBranch),
        .i_Zero           (i_Zero),
        .o_Fault          (o_Fault),
        .o_FetchState     (o_FetchState)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] expReqQ[$];
    logic [31:0] expInstrQ[$];
    logic [31:0] expPc = RESET_PC;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // instruction memory model (responds on the negedge, memLatency cycles after req)
    logic [31:0] memWord = W_RTYPE;
    int          memLatency = 1;
    logic        memSilent = 1'b0;
    logic        spurious = 1'b0;
    logic        pending = 1'b0;
    int          pendCnt = 0;
    int          latchedLat = 1;
    logic [31:0] respWord = 32'h0;

    always @(negedge i_clk) begin
        i_IMemValid = 1'b0;
        i_IMemData  = 32'h0;
        if (i_rst) begin
            pending = 1'b0;
        end else if (pending) begin
            pendCnt--;
            if (pendCnt == 0) begin
                i_IMemValid = 1'b1;
                i_IMemData  = respWord;
                pending     = 1'b0;
            end
        end else if (spurious && o_InstrValid) begin
            i_IMemValid = 1'b1;
            i_IMemData  = 32'hDEAD_BEEF;
        end
        if (!i_rst && o_IMemReq) begin
            pending    = !memSilent;
            pendCnt    = memLatency;
            latchedLat = memLatency;
            respWord   = memWord;
        end
    end

    // monitor: checks every request and every newly presented instruction
    int          cycle = 0;
    int          reqCycle = 0;
    logic        prevValid = 1'b0;
    logic [31:0] lastReqExp = RESET_PC;

    always @(posedge i_clk) begin
        #1;
        cycle++;
        if (o_IMemReq) begin
            if (expReqQ.size() == 0) begin
                check32("unexpected_req_addr", o_IMemAddr, 32'hFFFF_FFFF);
            end else begin
                lastReqExp = expReqQ.pop_front();
                check32("req_addr", o_IMemAddr, lastReqExp);
            end
            reqCycle = cycle;
        end
        if (o_InstrValid && !prevValid) begin
            if (expInstrQ.size() == 0) begin
                check32("unexpected_instr", o_Instr, 32'hFFFF_FFFF);
            end else begin
                check32("instr", o_Instr, expInstrQ.pop_front());
            end
            check32("pc", o_PC, lastReqExp);
            check32("pc_plus4", o_PCPlus4, lastReqExp + 32'd4);
            check32("resp_to_valid_cycles", cycle - reqCycle, latchedLat + 1);
        end
        prevValid = o_InstrValid;
    end

    // driver tasks
    task automatic doReset();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check32("rst_state", {29'b0, o_FetchState}, 32'(S_IDLE));
        check32("rst_req", {31'b0, o_IMemReq}, 32'd0);
        check32("rst_addr", o_IMemAddr, RESET_PC);
        check32("rst_instr", o_Instr, 32'h0);
        check32("rst_pc", o_PC, RESET_PC);
        check32("rst_pc_plus4", o_PCPlus4, RESET_PC + 32'd4);
        check32("rst_valid", {31'b0, o_InstrValid}, 32'd0);
        check32("rst_fault", {31'b0, o_Fault}, 32'd0);
        expReqQ.delete();
        expInstrQ.delete();
        expReqQ.push_back(RESET_PC);
        expPc = RESET_PC;
        i_rst = 1'b0;
    endtask

    task automatic step(input logic [31:0] word, input int lat,
                        input logic jmp, input logic br, input logic bne, input logic zr,
                        input logic [31:0] expNext, input int hold);
        int n;
        memWord    = word;
        memLatency = lat;
        expInstrQ.push_back(word);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_InstrValid && n < 200);
        if (!o_InstrValid) begin
            failNow("wait_instr_valid_timeout");
            return;
        end
        spurious = (hold > 0);
        repeat (hold) begin
            check32("hold_instr", o_Instr, word);
            check32("hold_pc", o_PC, expPc);
            check32("hold_no_req", {31'b0, o_IMemReq}, 32'd0);
            check32("hold_valid", {31'b0, o_InstrValid}, 32'd1);
            @(negedge i_clk);
        end
        spurious = 1'b0;
        expReqQ.push_back(expNext);
        i_InstrAccept    = 1'b1;
        i_Jump           = jmp;
        i_Branch         = br;
        i_NotEqualBranch = bne;
        i_Zero           = zr;
        @(posedge i_clk);
        #1;
        i_InstrAccept    = 1'b0;
        i_Jump           = 1'b0;
        i_Branch         = 1'b0;
        i_NotEqualBranch = 1'b0;
        i_Zero           = 1'b0;
        expPc = expNext;
    endtask

    initial begin
        int n;
        memWord = W_RTYPE;
        @(posedge i_clk);
        #1;
        doReset();

        // sequential fetch, one stall with spurious responses
        step(W_RTYPE, 1, 0, 0, 0, 0, 32'h0000_0004, 0);
        step(W_RTYPE, 1, 0, 0, 0, 0, 32'h0000_0008, 3);
        // BEQ taken backwards, BEQ not taken, jump, BNE taken
        step(W_BEQ_M2, 2, 0, 1, 0, 1, 32'h0000_0004, 0);
        step(W_RTYPE, 1, 0, 0, 0, 0, 32'h0000_0008, 0);
        step(W_BEQ_M2, 1, 0, 1, 0, 0, 32'h0000_000C, 0);
        step(W_J_2, 3, 1, 0, 0, 0, 32'h0000_0008, 0);
        step(W_BNE_3, 1, 0, 0, 1, 0, 32'h0000_0018, 0);
        // jump beats a taken branch; walk into the 0x1 region
        step(W_J_MAX, 1, 1, 1, 0, 1, 32'h0FFF_FFFC, 0);
        step(W_RTYPE, 1, 0, 0, 0, 0, 32'h1000_0000, 0);
        step(W_J_40, 1, 1, 1, 0, 1, 32'h1000_0100, 0);
        step(W_BNE_3, 1, 0, 0, 1, 1, 32'h1000_0104, 0);

        // reset while the request is out, then wrap around the address space
        doReset();
        step(W_BEQ_M2, 1, 0, 1, 0, 1, 32'hFFFF_FFFC, 0);
        step(W_RTYPE, 1, 0, 0, 0, 0, 32'h0000_0000, 0);
        check32("wrap_no_fault", {31'b0, o_Fault}, 32'd0);
        // response on the timeout limit cycle
        step(W_RTYPE, TIMEOUT_CYC, 0, 0, 0, 0, 32'h0000_0004, 0);
        check32("limit_no_fault", {31'b0, o_Fault}, 32'd0);

        // silent memory: fault after TIMEOUT_CYC wait cycles, sticky
        memSilent = 1'b1;
        n = 0;
        while (!o_Fault && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check32("fault_latency", n, TIMEOUT_CYC + 1);
        repeat (5) begin
            @(posedge i_clk);
            #1;
            check32("fault_sticky", {31'b0, o_Fault}, 32'd1);
            check32("fault_state", {29'b0, o_FetchState}, 32'(S_FAULT));
            check32("fault_no_valid", {31'b0, o_InstrValid}, 32'd0);
            check32("fault_no_req", {31'b0, o_IMemReq}, 32'd0);
        end
        memSilent = 1'b0;
        doReset();

        // reset during S_WAIT
        memLatency = 5;
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        check32("in_wait_state", {29'b0, o_FetchState}, 32'(S_WAIT));
        doReset();
        step(W_RTYPE, 1, 0, 0, 0, 0, 32'h0000_0004, 0);

        memSilent = 1'b1;
        repeat (2) @(posedge i_clk);
        #2;
        check32("req_queue_drained", expReqQ.size(), 32'd0);
        check32("instr_queue_drained", expInstrQ.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
